// File: rtl/interrupt_controller.sv
// Interrupt controller: latches rising edges of peripheral request lines into IF,
// masks them with IE toward the CPU, and clears the highest-priority bit on ack.
module interrupt_controller #(
  parameter logic [15:0] IF_ADDR = 16'hFF0F,
  parameter logic [15:0] IE_ADDR = 16'hFFFF,
  parameter int unsigned N_SRC   = 5
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cpu_en,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wdata,
  input  logic        i_write,
  output logic [7:0]  o_rdata,
  output logic        o_hit,
  input  logic [4:0]  i_irq_src,
  output logic [4:0]  o_ints,
  input  logic        i_int_ack,
  output logic        o_int_pending,
  output logic        o_ack_err
);

  logic [N_SRC-1:0] r_if;
  logic [7:0]       r_ie;
  logic [N_SRC-1:0] r_src_prev;
  logic             r_ack_err;

  logic [N_SRC-1:0] w_if_d;
  logic [N_SRC-1:0] w_edge_set;
  logic [N_SRC-1:0] w_ints;
  logic [N_SRC-1:0] w_ack_mask;
  logic [N_SRC-1:0] w_base;
  logic             w_hit_if;
  logic             w_hit_ie;
  logic             w_wr_if;
  logic             w_wr_ie;
  logic             w_ack;

  assign w_hit_if   = (i_addr == IF_ADDR);
  assign w_hit_ie   = (i_addr == IE_ADDR);
  assign w_wr_if    = i_write & i_cpu_en & w_hit_if;
  assign w_wr_ie    = i_write & i_cpu_en & w_hit_ie;
  assign w_ack      = i_int_ack & i_cpu_en;
  assign w_edge_set = i_irq_src & ~r_src_prev;
  assign w_ints     = r_if & r_ie[N_SRC-1:0];
  // Isolate the lowest set bit: bit 0 has the highest priority.
  assign w_ack_mask = w_ints & (~w_ints + 5'd1);

  always_comb begin
    w_base = w_wr_if ? i_wdata[N_SRC-1:0] : r_if;
    if (w_ack) begin
      w_base = w_base & ~w_ack_mask;
    end
    // A fresh edge always wins over a clear in the same cycle.
    w_if_d = w_base | w_edge_set;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_if       <= '0;
      r_ie       <= 8'h00;
      r_src_prev <= '0;
      r_ack_err  <= 1'b0;
    end else begin
      r_src_prev <= i_irq_src;
      r_if       <= w_if_d;
      if (w_wr_ie) begin
        r_ie <= i_wdata;
      end
      if (w_ack && (w_ints == '0)) begin
        r_ack_err <= 1'b1;
      end
    end
  end

  always_comb begin
    o_rdata = 8'hFF;
    if (w_hit_if) begin
      o_rdata = {3'b111, r_if};
    end else if (w_hit_ie) begin
      o_rdata = r_ie;
    end
  end

  assign o_hit         = w_hit_if | w_hit_ie;
  assign o_ints        = w_ints;
  assign o_int_pending = |w_ints;
  assign o_ack_err     = r_ack_err;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench: directed literal checks plus randomized traffic compared
// every cycle against a bit-level behavioural model of IF/IE.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_en = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        write = 1'b0;
  logic [7:0]  rdata;
  logic        hit;
  logic [4:0]  irq_src = 5'b0;
  logic [4:0]  ints;
  logic        int_ack = 1'b0;
  logic        int_pending;
  logic        ack_err;

  int n_chk  = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  interrupt_controller dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_cpu_en      (cpu_en),
    .i_addr        (addr),
    .i_wdata       (wdata),
    .i_write       (write),
    .o_rdata       (rdata),
    .o_hit         (hit),
    .i_irq_src     (irq_src),
    .o_ints        (ints),
    .i_int_ack     (int_ack),
    .o_int_pending (int_pending),
    .o_ack_err     (ack_err)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit [4:0] m_if;
  bit [7:0] m_ie;
  bit [4:0] m_prev;
  bit       m_err;

  function automatic bit [4:0] model_next_if();
    bit [4:0] pend;
    bit [4:0] nxt;
    int       first;
    pend  = m_if & m_ie[4:0];
    first = -1;
    for (int i = 0; i < 5; i++) begin
      if (pend[i] && first < 0) first = i;
    end
    for (int i = 0; i < 5; i++) begin
      bit b;
      b = (write && cpu_en && addr == 16'hFF0F) ? wdata[i] : m_if[i];
      if (int_ack && cpu_en && i == first) b = 1'b0;
      if (irq_src[i] && !m_prev[i]) b = 1'b1;
      nxt[i] = b;
    end
    return nxt;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_if   <= '0;
      m_ie   <= '0;
      m_prev <= '0;
      m_err  <= 1'b0;
    end else begin
      m_if   <= model_next_if();
      m_prev <= irq_src;
      if (write && cpu_en && addr == 16'hFFFF) m_ie <= wdata;
      if (int_ack && cpu_en && (m_if & m_ie[4:0]) == 5'd0) m_err <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Compare process: every cycle, mid-low-phase, DUT outputs vs model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [4:0] e_ints;
      logic [7:0] e_rd;
      e_ints = m_if & m_ie[4:0];
      e_rd   = (addr == 16'hFF0F) ? {3'b111, m_if} : (addr == 16'hFFFF) ? m_ie : 8'hFF;
      check("ints", {3'b0, ints}, {3'b0, e_ints});
      check("int_pending", {7'b0, int_pending}, {7'b0, |e_ints});
      check("ack_err", {7'b0, ack_err}, {7'b0, m_err});
      check("rdata", rdata, e_rd);
      check("hit", {7'b0, hit}, {7'b0, (addr == 16'hFF0F || addr == 16'hFFFF)});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write = 1'b0; int_ack = 1'b0; cpu_en = 1'b1; addr = 16'h0000;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; wdata = d; write = 1'b1; cyc(); idle();
  endtask

  task automatic ack_once();
    int_ack = 1'b1; cyc(); idle();
  endtask

  task automatic rd(input string name, input logic [15:0] a, input logic [7:0] exp);
    addr = a; #1; check(name, rdata, exp);
  endtask

  initial begin
    cyc(); cyc();
    rst_n = 1'b1;
    chk_en = 1'b1;
    cyc();

    // Reset state
    rd("rst_if", 16'hFF0F, 8'hE0);
    check("rst_hit", {7'b0, hit}, 8'h01);
    rd("rst_ie", 16'hFFFF, 8'h00);
    check("rst_ints", {3'b0, ints}, 8'h00);
    check("rst_err", {7'b0, ack_err}, 8'h00);
    rd("miss_rd", 16'h1234, 8'hFF);
    check("miss_hit", {7'b0, hit}, 8'h00);

    // Edge latch and mask
    wr(16'hFFFF, 8'h1F);
    irq_src = 5'b00100;
    cyc(); cyc(); cyc();
    rd("edge_if", 16'hFF0F, 8'hE4);
    check("edge_ints", {3'b0, ints}, 8'h04);
    check("edge_pend", {7'b0, int_pending}, 8'h01);
    wr(16'hFF0F, 8'h00);
    cyc();
    rd("held_if", 16'hFF0F, 8'hE0);
    irq_src = 5'b0;
    cyc();

    // Priority ack
    wr(16'hFF0F, 8'h16);
    check("pri_ints", {3'b0, ints}, 8'h16);
    ack_once(); rd("pri_ack1", 16'hFF0F, 8'hF4);
    ack_once(); rd("pri_ack2", 16'hFF0F, 8'hF0);
    ack_once(); rd("pri_ack3", 16'hFF0F, 8'hE0);
    check("pri_err", {7'b0, ack_err}, 8'h00);

    // Masking and ack error
    wr(16'hFFFF, 8'h04);
    wr(16'hFF0F, 8'h03);
    check("mask_ints", {3'b0, ints}, 8'h00);
    check("mask_pend", {7'b0, int_pending}, 8'h00);
    ack_once();
    rd("mask_if", 16'hFF0F, 8'hE3);
    check("mask_err", {7'b0, ack_err}, 8'h01);
    #2 rst_n = 1'b0; #2 rst_n = 1'b1;
    check("err_clr", {7'b0, ack_err}, 8'h00);
    cyc();

    // Collisions
    wr(16'hFFFF, 8'h1F);
    addr = 16'hFF0F; wdata = 8'h00; write = 1'b1; irq_src = 5'b00001;
    cyc(); idle();
    rd("col_wr", 16'hFF0F, 8'hE1);
    irq_src = 5'b0; cyc();
    int_ack = 1'b1; irq_src = 5'b00001; cyc(); idle();
    rd("col_ack", 16'hFF0F, 8'hE1);
    irq_src = 5'b0; cyc();

    // cpu_en gating
    cpu_en = 1'b0; addr = 16'hFFFF; wdata = 8'h00; write = 1'b1; int_ack = 1'b1;
    irq_src = 5'b10000;
    cyc(); idle();
    rd("gate_ie", 16'hFFFF, 8'h1F);
    rd("gate_if", 16'hFF0F, 8'hF1);
    check("gate_err", {7'b0, ack_err}, 8'h00);
    irq_src = 5'b0; cyc();

    // Randomized traffic, checked by the compare process
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel     = $urandom_range(0, 3);
      addr    = (sel == 0) ? 16'hFF0F : (sel == 1) ? 16'hFFFF : (sel == 2) ? 16'hFF0E
                : 16'($urandom);
      wdata   = 8'($urandom);
      write   = ($urandom_range(0, 9) < 2);
      cpu_en  = ($urandom_range(0, 3) != 0);
      int_ack = ($urandom_range(0, 4) == 0);
      irq_src = irq_src ^ (5'($urandom) & 5'($urandom));
      if ($urandom_range(0, 9) == 0) wr(16'hFFFF, 8'($urandom) | 8'h01);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0; #1 rst_n = 1'b1;
      end
      cyc();
    end

    idle();
    cyc();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
